pwm_fade_scheduler: RTL

- Sequences a PWM output through a repeating "breathing" profile: ramp up, hold high, ramp down, hold low.
- Contains its own PWM timebase and a duty scheduler FSM, so it replaces a fixed-duty PwmGenerator instance wherever an LED or actuator needs a time-varying duty.
- Sits between top-level controls (enable/freeze, e.g. from KEY) and an output pin.

---
 rtl/pwm_fade_scheduler.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pwm_fade_scheduler.sv
// pwm_fade_scheduler: PWM timebase plus a duty scheduler that walks the
// output through a repeating breathing profile (ramp up, hold high,
// ramp down, hold low). Duty, state and scheduler counters only move at
// the last cycle of a PWM period, so every period is emitted with one
// stable duty and the output never glitches mid-period.
//
// Interface timing: there is no valid/ready handshake. period_tick is a
// one-cycle strobe marking the first cycle of each new PWM period. duty
// and phase are register outputs, and phase doubles as the FSM debug view.
module pwm_fade_scheduler #(
  parameter int F            = 50_000_000,
  parameter int HZ           = 1000,
  parameter int DUTY_STEP    = 1,
  parameter int STEP_PERIODS = 10,
  parameter int HOLD_PERIODS = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       freeze,
  output logic       pin,
  output logic [6:0] duty,
  output logic [2:0] phase,
  output logic       period_tick
);

  localparam int PERIOD = F / HZ;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  // Compare width holds PERIOD*100 without truncation.
  localparam int MW     = $clog2(PERIOD * 100) + 1;
  localparam int SW     = $clog2(STEP_PERIODS + 1);
  localparam int HW     = $clog2(HOLD_PERIODS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [6:0]    duty_q, duty_n;
  logic [SW-1:0] step_cnt, step_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          boundary;
  logic [6:0]    duty_up, duty_dn;
  logic [MW-1:0] cmp_lhs, cmp_rhs;

  assign boundary = (cnt == CW'(PERIOD - 1));

  // Saturating duty step in both directions.
  assign duty_up = (duty_q >= 7'(100 - DUTY_STEP)) ? 7'd100 : duty_q + 7'(DUTY_STEP);
  assign duty_dn = (duty_q <= 7'(DUTY_STEP)) ? 7'd0 : duty_q - 7'(DUTY_STEP);

  assign cmp_lhs = MW'(cnt) * MW'(100);
  assign cmp_rhs = MW'(duty_q) * MW'(PERIOD);

  // Free-running timebase, registered PWM compare and period strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      pin         <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      cnt         <= boundary ? '0 : cnt + CW'(1);
      pin         <= (cmp_lhs < cmp_rhs);
      period_tick <= boundary;
    end
  end

  // Scheduler state register: state, duty and step/hold counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      duty_q   <= '0;
      step_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      duty_q   <= duty_n;
      step_cnt <= step_n;
      hold_cnt <= hold_n;
    end
  end

  // Next-state logic, evaluated only at a period boundary; en=0 aborts
  // to IDLE even while frozen.
  always_comb begin
    state_n = state;
    duty_n  = duty_q;
    step_n  = step_cnt;
    hold_n  = hold_cnt;
    if (boundary) begin
      if (!en) begin
        state_n = IDLE;
        duty_n  = '0;
        step_n  = '0;
        hold_n  = '0;
      end else if (!freeze) begin
        case (state)
          IDLE: begin
            state_n = UP;
            duty_n  = '0;
            step_n  = '0;
            hold_n  = '0;
          end
          UP: begin
            if (step_cnt == SW'(STEP_PERIODS - 1)) begin
              step_n = '0;
              duty_n = duty_up;
              if (duty_up == 7'd100) begin
                state_n = HOLD_HI;
                hold_n  = '0;
              end
            end else begin
              step_n = step_cnt + SW'(1);
            end
          end
          HOLD_HI: begin
            if (hold_cnt == HW'(HOLD_PERIODS - 1)) begin
              state_n = DOWN;
              step_n  = '0;
              hold_n  = '0;
            end else begin
              hold_n = hold_cnt + HW'(1);
            end
          end
          DOWN: begin
            if (step_cnt == SW'(STEP_PERIODS - 1)) begin
              step_n = '0;
              duty_n = duty_dn;
              if (duty_dn == 7'd0) begin
                state_n = HOLD_LO;
                hold_n  = '0;
              end
            end else begin
              step_n = step_cnt + SW'(1);
            end
          end
          HOLD_LO: begin
            if (hold_cnt == HW'(HOLD_PERIODS - 1)) begin
              state_n = UP;
              step_n  = '0;
              hold_n  = '0;
            end else begin
              hold_n = hold_cnt + HW'(1);
            end
          end
          default: begin
            state_n = IDLE;
            duty_n  = '0;
            step_n  = '0;
            hold_n  = '0;
          end
        endcase
      end
    end
  end

  // Output view of the scheduler registers.
  always_comb begin
    duty  = duty_q;
    phase = state;
  end

endmodule
